// File: rtl/avs_arb_pkg.sv
// Shared definitions for the two-port Avalon-MM register-slave arbiter.
//   ST_*               : FSM state encodings (2-bit, legacy-compatible constants)
//   TIMEOUT_DATA_DEF   : default readdata returned on an aborted transfer
//   rw_resolve()       : applies read-over-write priority to one master's strobes
package avs_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

    // Returns {write, read}. A master raising both strobes gets a read.
    function automatic logic [1:0] rw_resolve(input logic rd, input logic wr);
        return {wr & ~rd, rd};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker (combinational).
//   req[1:0]   : in  request per port
//   last_grant : in  index of the port granted most recently
//   grant[1:0] : out one-hot pick, 00 when nothing requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/avs_arb2_wait32.sv
// Two-master round-robin arbiter in front of one 32-bit waitrequest slave,
// with a per-transfer stall timeout and sticky abort flag.
//   csi_MCLK_clk, rsi_MRST_reset (async, active-high)
//   avs_s0_* / avs_s1_* : slave-side ports facing the two masters
//   avm_m_*             : master-side port to the shared register slave
//   coe_grant           : one-hot current owner, 00 when idle
//   coe_timeout         : sticky abort flag, cleared by coe_timeout_clr
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | nothing forwarded; arbitrate pending requests
// ST_BUSY  | granted master's transfer is driven onto the slave
// ST_ABORT | one-cycle fake completion to the granted master after timeout
module avs_arb2_wait32
    import avs_arb_pkg::*;
#(
    parameter int          ADDR_W       = 6,
    parameter int          TIMEOUT      = 64,
    parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
    input  logic              rsi_MRST_reset,
    input  logic              csi_MCLK_clk,

    input  logic [ADDR_W-1:0] avs_s0_address,
    input  logic [31:0]       avs_s0_writedata,
    input  logic [3:0]        avs_s0_byteenable,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    output logic [31:0]       avs_s0_readdata,
    output logic              avs_s0_waitrequest,

    input  logic [ADDR_W-1:0] avs_s1_address,
    input  logic [31:0]       avs_s1_writedata,
    input  logic [3:0]        avs_s1_byteenable,
    input  logic              avs_s1_read,
    input  logic              avs_s1_write,
    output logic [31:0]       avs_s1_readdata,
    output logic              avs_s1_waitrequest,

    output logic [ADDR_W-1:0] avm_m_address,
    output logic [31:0]       avm_m_writedata,
    output logic [3:0]        avm_m_byteenable,
    output logic              avm_m_read,
    output logic              avm_m_write,
    input  logic [31:0]       avm_m_readdata,
    input  logic              avm_m_waitrequest,

    output logic [1:0]        coe_grant,
    output logic              coe_timeout,
    input  logic              coe_timeout_clr
);

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [1:0]        grant_q;
    logic              last_grant;
    logic [15:0]       wait_cnt;

    logic [1:0]        req;
    logic [1:0]        pick;
    logic              sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_be;
    logic              sel_rd;
    logic              sel_wr;
    logic [1:0]        sel_rw;
    logic              in_busy;
    logic              fwd_rd;
    logic              fwd_wr;
    logic              xfer_done;

    assign req = {avs_s1_read | avs_s1_write, avs_s0_read | avs_s0_write};

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick)
    );

    assign sel       = grant_q[1];
    assign sel_addr  = sel ? avs_s1_address    : avs_s0_address;
    assign sel_wdata = sel ? avs_s1_writedata  : avs_s0_writedata;
    assign sel_be    = sel ? avs_s1_byteenable : avs_s0_byteenable;
    assign sel_rd    = sel ? avs_s1_read       : avs_s0_read;
    assign sel_wr    = sel ? avs_s1_write      : avs_s0_write;
    assign sel_rw    = rw_resolve(sel_rd, sel_wr);

    assign in_busy   = (state == ST_BUSY);
    assign fwd_rd    = in_busy & sel_rw[0];
    assign fwd_wr    = in_busy & sel_rw[1];
    assign xfer_done = (fwd_rd | fwd_wr) & ~avm_m_waitrequest;

    assign coe_grant = grant_q;

    always_comb begin
        avm_m_read         = fwd_rd;
        avm_m_write        = fwd_wr;
        avm_m_address      = in_busy ? sel_addr  : '0;
        avm_m_writedata    = in_busy ? sel_wdata : '0;
        avm_m_byteenable   = in_busy ? sel_be    : '0;
        avs_s0_waitrequest = 1'b1;
        avs_s1_waitrequest = 1'b1;
        avs_s0_readdata    = '0;
        avs_s1_readdata    = '0;
        if (in_busy) begin
            if (grant_q[0]) begin
                avs_s0_waitrequest = avm_m_waitrequest;
                avs_s0_readdata    = avm_m_readdata;
            end
            if (grant_q[1]) begin
                avs_s1_waitrequest = avm_m_waitrequest;
                avs_s1_readdata    = avm_m_readdata;
            end
        end else if (state == ST_ABORT) begin
            // Granted master sees a completed transfer; a write is simply lost.
            if (grant_q[0]) begin
                avs_s0_waitrequest = 1'b0;
                avs_s0_readdata    = TIMEOUT_DATA;
            end
            if (grant_q[1]) begin
                avs_s1_waitrequest = 1'b0;
                avs_s1_readdata    = TIMEOUT_DATA;
            end
        end
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state       <= ST_IDLE;
            grant_q     <= 2'b00;
            last_grant  <= 1'b1;
            wait_cnt    <= '0;
            coe_timeout <= 1'b0;
        end else begin
            // Setting in ABORT wins over a simultaneous clear.
            if (state == ST_ABORT) begin
                coe_timeout <= 1'b1;
            end else if (coe_timeout_clr) begin
                coe_timeout <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (|pick) begin
                        grant_q    <= pick;
                        last_grant <= pick[1];
                        wait_cnt   <= '0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (xfer_done) begin
                        grant_q  <= 2'b00;
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (!(sel_rd | sel_wr)) begin
                        // Master withdrew its request mid-stall: drop it quietly.
                        grant_q <= 2'b00;
                        state   <= ST_IDLE;
                    end else if (avm_m_waitrequest) begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            state <= ST_ABORT;
                        end
                    end
                end
                ST_ABORT: begin
                    grant_q <= 2'b00;
                    state   <= ST_IDLE;
                end
                default: begin
                    grant_q <= 2'b00;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
